// File: rtl/i2c_master_byte_ctrl.sv
// Single-byte I2C master: START, address+R/W, address ACK, one data byte, STOP.
// Bus timing is paced by a quarter-bit strobe (qtick) from an external SCL divider.
module i2c_master_byte_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              qtick,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              sda_i,
  output logic              scl_o,
  output logic              sda_oe,
  output logic              busy,
  output logic              done,
  output logic              ack_err,
  output logic [DATA_W-1:0] rdata,
  output logic [3:0]        dbg_state
);

  localparam int SH_W  = ADDR_W + 1;
  localparam int MAX_W = (SH_W > DATA_W) ? SH_W : DATA_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ACK_A, S_WDATA, S_ACK_W, S_RDATA, S_MNACK, S_STOP
  } state_t;

  state_t            state;
  logic [1:0]        phase;
  logic [CNT_W-1:0]  cnt;
  logic [SH_W-1:0]   sh;
  logic [DATA_W-1:0] wbyte;
  logic              rw_q;
  logic              nack;

  assign dbg_state = state;

  // Every non-idle state consumes one q0..q3 cycle per bit; phase 3 is where
  // SCL falls and the state/bit counter advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      phase   <= 2'd0;
      cnt     <= '0;
      sh      <= '0;
      wbyte   <= '0;
      rw_q    <= 1'b0;
      nack    <= 1'b0;
      scl_o   <= 1'b1;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= '0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (start) begin
          sh      <= {addr, rw};
          wbyte   <= wdata;
          rw_q    <= rw;
          busy    <= 1'b1;
          ack_err <= 1'b0;
          phase   <= 2'd0;
          state   <= S_START;
        end
      end else if (qtick) begin
        phase <= phase + 2'd1;
        case (state)
          S_START: begin
            case (phase)
              2'd2: sda_oe <= 1'b1;
              2'd3: begin
                scl_o <= 1'b0;
                cnt   <= CNT_W'(SH_W - 1);
                state <= S_ADDR;
              end
              default: sda_oe <= 1'b0;
            endcase
          end
          S_ADDR, S_WDATA, S_RDATA: begin
            case (phase)
              2'd0: begin
                if (state == S_ADDR)       sda_oe <= ~sh[cnt];
                else if (state == S_WDATA) sda_oe <= ~wbyte[cnt];
                else                       sda_oe <= 1'b0;
              end
              2'd1: scl_o <= 1'b1;
              2'd2: if (state == S_RDATA) rdata <= {rdata[DATA_W-2:0], sda_i};
              default: begin
                scl_o <= 1'b0;
                if (cnt == '0) begin
                  if (state == S_ADDR)       state <= S_ACK_A;
                  else if (state == S_WDATA) state <= S_ACK_W;
                  else                       state <= S_MNACK;
                end else begin
                  cnt <= cnt - 1'b1;
                end
              end
            endcase
          end
          S_ACK_A, S_ACK_W: begin
            case (phase)
              2'd0: sda_oe <= 1'b0;
              2'd1: scl_o <= 1'b1;
              2'd2: begin
                nack <= sda_i;
                if (sda_i) ack_err <= 1'b1;
              end
              default: begin
                scl_o <= 1'b0;
                // An address NACK skips the data byte entirely.
                if (state == S_ACK_W || nack) begin
                  state <= S_STOP;
                end else begin
                  cnt   <= CNT_W'(DATA_W - 1);
                  state <= rw_q ? S_RDATA : S_WDATA;
                end
              end
            endcase
          end
          S_MNACK: begin
            case (phase)
              2'd0: sda_oe <= 1'b0;
              2'd1: scl_o <= 1'b1;
              2'd3: begin
                scl_o <= 1'b0;
                state <= S_STOP;
              end
              default: ;
            endcase
          end
          S_STOP: begin
            case (phase)
              2'd0: sda_oe <= 1'b1;
              2'd1: scl_o <= 1'b1;
              2'd2: sda_oe <= 1'b0;
              default: begin
                state <= S_IDLE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
            endcase
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Bench for i2c_master_byte_ctrl: a per-bit-period bus model predicts SCL/SDA,
// busy, done, ack_err and rdata after every qtick; an open-drain slave answers.
module tb_i2c_master_byte_ctrl;

  localparam int K_START = 0, K_DRIVE = 1, K_REL = 2, K_STOP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       qtick = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       sda_i;
  logic       scl_o, sda_oe, busy, done, ack_err;
  logic [7:0] rdata;
  logic [3:0] dbg_state;

  i2c_master_byte_ctrl #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .qtick(qtick), .start(start), .rw(rw),
    .addr(addr), .wdata(wdata), .sda_i(sda_i), .scl_o(scl_o),
    .sda_oe(sda_oe), .busy(busy), .done(done), .ack_err(ack_err),
    .rdata(rdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- qtick generator (also runs while idle) ----------------
  int qgap_lo = 2, qgap_hi = 2;
  initial begin
    forever begin
      int gap;
      gap = $urandom_range(qgap_hi, qgap_lo);
      @(posedge clk); #1; qtick = 1'b1;
      @(posedge clk); #1; qtick = 1'b0;
      repeat (gap - 2) @(posedge clk);
    end
  end

  // ---------------- behavioural bus model ----------------
  bit         exp_scl [0:79];
  bit         exp_oe  [0:79];
  bit         slv     [0:19];
  int         bp;
  int         m_total, m_nack_idx;
  bit         m_rd_valid;
  logic [7:0] m_rd_exp;
  logic [7:0] exp_q[$];

  bit         m_active, m_scl, m_oe, m_busy, m_done, m_ack_err;
  int         m_q;
  logic [7:0] m_rdata;

  // One bit period: SCL/SDA-enable after each of its four qticks, plus slave level.
  task automatic put_period(input int kind, input bit b, input bit sb);
    for (int j = 0; j < 4; j++) begin
      case (kind)
        K_START: begin exp_scl[4*bp+j] = (j != 3); exp_oe[4*bp+j] = (j >= 2); end
        K_DRIVE: begin exp_scl[4*bp+j] = (j == 1 || j == 2); exp_oe[4*bp+j] = ~b; end
        K_REL:   begin exp_scl[4*bp+j] = (j == 1 || j == 2); exp_oe[4*bp+j] = 1'b0; end
        default: begin exp_scl[4*bp+j] = (j != 0); exp_oe[4*bp+j] = (j <= 1); end
      endcase
    end
    slv[bp] = sb;
    bp++;
  endtask

  task automatic build_model(input logic [6:0] a, input logic r, input logic [7:0] wd,
                             input bit ack_a, input bit ack_w, input logic [7:0] rb);
    logic [7:0] ab;
    ab = {a, r};
    bp = 0;
    m_nack_idx = -1;
    m_rd_valid = 1'b0;
    m_rd_exp = rb;
    for (int i = 0; i < 20; i++) slv[i] = 1'b1;
    put_period(K_START, 1'b0, 1'b1);
    for (int i = 7; i >= 0; i--) put_period(K_DRIVE, ab[i], 1'b1);
    if (!ack_a) m_nack_idx = 4*bp + 2;
    put_period(K_REL, 1'b0, !ack_a);
    if (ack_a) begin
      if (!r) begin
        for (int i = 7; i >= 0; i--) put_period(K_DRIVE, wd[i], 1'b1);
        if (!ack_w) m_nack_idx = 4*bp + 2;
        put_period(K_REL, 1'b0, !ack_w);
      end else begin
        for (int i = 7; i >= 0; i--) put_period(K_REL, 1'b0, rb[i]);
        put_period(K_REL, 1'b0, 1'b1);
        m_rd_valid = 1'b1;
      end
    end
    put_period(K_STOP, 1'b0, 1'b1);
    m_total = 4*bp;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0; m_q <= 0; m_scl <= 1'b1; m_oe <= 1'b0;
      m_busy <= 1'b0; m_done <= 1'b0; m_ack_err <= 1'b0; m_rdata <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_active) begin
        if (start) begin
          m_active <= 1'b1; m_busy <= 1'b1; m_ack_err <= 1'b0; m_q <= 0;
        end
      end else if (qtick) begin
        m_scl <= exp_scl[m_q];
        m_oe  <= exp_oe[m_q];
        if (m_q == m_nack_idx) m_ack_err <= 1'b1;
        m_q <= m_q + 1;
        if (m_q + 1 == m_total) begin
          m_active <= 1'b0; m_busy <= 1'b0; m_done <= 1'b1;
          if (m_rd_valid) m_rdata <= m_rd_exp;
        end
      end
    end
  end

  // Open-drain slave: wired-AND of master enable and slave level for the current period.
  logic slave_bit, sda_line;
  always_comb begin
    slave_bit = 1'b1;
    if (m_active && (m_q / 4) < 20) slave_bit = slv[m_q / 4];
  end
  assign sda_line = sda_oe ? 1'b0 : slave_bit;
  assign sda_i = sda_line;

  // ---------------- compare process and bus monitor ----------------
  logic bits_q[$];
  int   high_edges, done_cnt, dut_qt;
  logic prev_scl = 1'b1, prev_oe = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      check("scl", scl_o, m_scl);
      check("sda_oe", sda_oe, m_oe);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("ack_err", ack_err, m_ack_err);
      if (!m_busy) check("rdata", rdata, m_rdata);
      if (scl_o && !prev_scl) bits_q.push_back(sda_line);
      if (scl_o && prev_scl && sda_oe != prev_oe) high_edges++;
      if (done) done_cnt++;
      if (busy && qtick) dut_qt++;
    end
    prev_scl = scl_o;
    prev_oe  = sda_oe;
  end

  function automatic logic [7:0] qbyte(input int s);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      v = {v[6:0], (s + i < bits_q.size()) ? bits_q[s + i] : 1'b0};
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [6:0] a, input logic r, input logic [7:0] wd,
                        input bit ack_a, input bit ack_w, input logic [7:0] rb);
    build_model(a, r, wd, ack_a, ack_w, rb);
    if (r && ack_a) exp_q.push_back(rb);
    bits_q.delete();
    high_edges = 0; done_cnt = 0; dut_qt = 0;
    @(posedge clk); #1;
    start = 1'b1; addr = a; rw = r; wdata = wd;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_q(input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(posedge clk); #2;
      if (m_q >= n) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_qtick actual=%0d required=%0d", m_q, n);
    end
  endtask

  task automatic wait_done(input bit r, input bit ack_a, output int qt);
    bit seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1'b1);
    if (seen && r && ack_a && exp_q.size() > 0) check("rdata_read", rdata, exp_q.pop_front());
    repeat (3) @(negedge clk);
    qt = dut_qt;
    check("done_once", done_cnt, 1);
    check("busy_after", busy, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int qt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_scl", scl_o, 1'b1);
    check("rst_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_state", dbg_state, 4'd0);
    repeat (10) @(posedge clk);

    // Write with ACKing slave at two qtick spacings; bus pattern must be identical.
    for (int g = 0; g < 2; g++) begin
      qgap_lo = (g == 0) ? 2 : 25;
      qgap_hi = qgap_lo;
      launch(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
      wait_done(1'b0, 1'b1, qt);
      check("wr_qticks", qt, 80);
      check("wr_scl_rises", bits_q.size(), 19);
      check("wr_addr_byte", qbyte(0), 8'hA0);
      check("wr_addr_ack", bits_q[8], 1'b0);
      check("wr_data_byte", qbyte(9), 8'hA5);
      check("wr_data_ack", bits_q[17], 1'b0);
      check("wr_start_stop_edges", high_edges, 2);
      check("wr_ack_err", ack_err, 1'b0);
    end

    qgap_lo = 2; qgap_hi = 5;
    // Read: slave returns 0x5A, master NACKs.
    launch(7'h3C, 1'b1, 8'h00, 1'b1, 1'b1, 8'h5A);
    wait_done(1'b1, 1'b1, qt);
    check("rd_qticks", qt, 80);
    check("rd_addr_byte", qbyte(0), 8'h79);
    check("rd_data_bits", qbyte(9), 8'h5A);
    check("rd_master_nack", bits_q[17], 1'b1);
    check("rd_rdata", rdata, 8'h5A);
    check("rd_ack_err", ack_err, 1'b0);

    // Address NACK: data phase skipped, STOP immediately.
    launch(7'h11, 1'b0, 8'hC3, 1'b0, 1'b1, 8'h00);
    wait_done(1'b0, 1'b0, qt);
    check("nack_qticks", qt, 44);
    check("nack_scl_rises", bits_q.size(), 10);
    check("nack_addr_byte", qbyte(0), 8'h22);
    check("nack_ack_bit", bits_q[8], 1'b1);
    check("nack_ack_err", ack_err, 1'b1);
    check("nack_rdata_kept", rdata, 8'h5A);

    // Start while busy is ignored.
    launch(7'h2A, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h00);
    wait_q(10);
    @(posedge clk); #1;
    start = 1'b1; addr = 7'h7F; rw = 1'b1; wdata = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, 1'b1, qt);
    check("dup_qticks", qt, 80);
    check("dup_addr_byte", qbyte(0), 8'h54);
    check("dup_data_byte", qbyte(9), 8'h3C);
    check("dup_ack_err", ack_err, 1'b0);

    // Reset during WDATA bit 3 (bit period 14).
    launch(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
    wait_q(4*14 + 1);
    rst = 1'b1;
    #1;
    check("mid_rst_scl", scl_o, 1'b1);
    check("mid_rst_oe", sda_oe, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_rst_no_done", done_cnt, 0);
    launch(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
    wait_done(1'b0, 1'b1, qt);
    check("post_rst_qticks", qt, 80);
    check("post_rst_data", qbyte(9), 8'hA5);

    // Randomized transactions.
    for (int n = 0; n < 12; n++) begin
      logic [6:0] a;
      logic [7:0] wd, rb;
      logic r;
      bit aa, aw;
      a = 7'($urandom_range(127, 0));
      wd = 8'($urandom_range(255, 0));
      rb = 8'($urandom_range(255, 0));
      r = 1'($urandom_range(1, 0));
      aa = ($urandom_range(3, 0) != 0);
      aw = ($urandom_range(3, 0) != 0);
      qgap_lo = 2;
      qgap_hi = $urandom_range(6, 2);
      launch(a, r, wd, aa, aw, rb);
      wait_done(r, aa, qt);
      check("rnd_qticks", qt, aa ? 80 : 44);
      check("rnd_addr_byte", qbyte(0), {a, r});
      check("rnd_ack_err", ack_err, !aa || (!r && !aw));
      repeat ($urandom_range(8, 0)) @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
